// File: rtl/fp_rnd_pipe.sv
// rtl/fp_rnd_pipe.sv - two-stage IEEE-754 round/pack pipeline for single/double; FP_RND_FTZ_EN selects flush-to-zero

package fp_rnd_pipe_pkg;

    typedef struct packed {
        logic        sig;
        logic [13:0] expo;
        logic [53:0] mant;
        logic [1:0]  rema;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [2:0]  grs;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        infs;
        logic        zero;
        logic        diff;
        logic        valid;
    } fp_rnd_in_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_rnd_out_type;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

endpackage

module fp_rnd_pipe
    import fp_rnd_pipe_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  fp_rnd_in_type  rnd_i,
    output logic           in_ready,
    output fp_rnd_out_type rnd_o,
    input  logic           out_ready
);

    function automatic logic [63:0] pack(input logic dbl, input logic s,
                                         input logic [10:0] e, input logic [51:0] m);
        if (dbl)
            pack = {s, e, m};
        else
            pack = {32'hFFFF_FFFF, s, e[7:0], m[22:0]};
    endfunction

    logic adv1;
    logic adv2;
    logic s1_valid;
    logic s2_valid;

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    logic unused_fmt;
    assign unused_fmt = rnd_i.fmt[1];

    logic in_dbl;
    logic in_st;
    logic in_inx;
    logic in_inc;
    logic in_all_ones;

    always_comb begin
        in_dbl      = rnd_i.fmt[0];
        in_st       = rnd_i.grs[0] | (|rnd_i.rema);
        in_inx      = rnd_i.grs[2] | rnd_i.grs[1] | in_st;
        in_all_ones = in_dbl ? (&rnd_i.mant[52:0]) : (&rnd_i.mant[23:0]);
        case (rnd_i.rm)
            RM_RTZ:  in_inc = 1'b0;
            RM_RDN:  in_inc = rnd_i.sig & in_inx;
            RM_RUP:  in_inc = !rnd_i.sig & in_inx;
            RM_RMM:  in_inc = rnd_i.grs[2];
            default: in_inc = rnd_i.grs[2] & (rnd_i.grs[1] | in_st | rnd_i.mant[0]);
        endcase
    end

    logic        s1_sig;
    logic [13:0] s1_expo;
    logic [53:0] s1_mant;
    logic        s1_inx;
    logic        s1_tiny;
    logic        s1_near_carry;
    logic        s1_dbl;
    logic [2:0]  s1_rm;
    logic        s1_snan;
    logic        s1_qnan;
    logic        s1_dbz;
    logic        s1_infs;
    logic        s1_zero;
    logic        s1_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (adv1)
            s1_valid <= rnd_i.valid;
    end

    // Overflow is judged on the nearest-away magnitude, so directed modes that
    // truncate a top-binade all-ones mantissa still report OF.
    always_ff @(posedge clk) begin
        if (adv1 && rnd_i.valid) begin
            s1_sig        <= rnd_i.sig;
            s1_expo       <= rnd_i.expo;
            s1_mant       <= rnd_i.mant + {53'd0, in_inc};
            s1_inx        <= in_inx;
            s1_tiny       <= (rnd_i.expo == 14'd0);
            s1_near_carry <= in_all_ones & rnd_i.grs[2];
            s1_dbl        <= in_dbl;
            s1_rm         <= rnd_i.rm;
            s1_snan       <= rnd_i.snan;
            s1_qnan       <= rnd_i.qnan;
            s1_dbz        <= rnd_i.dbz;
            s1_infs       <= rnd_i.infs;
            s1_zero       <= rnd_i.zero;
            s1_diff       <= rnd_i.diff;
        end
    end

    logic        carry;
    logic        hidden;
    logic [53:0] m_rnd;
    logic [14:0] e_rnd;
    logic [14:0] emax;
    logic        ovf;
    logic        to_inf;
    logic [10:0] e_all;
    logic [10:0] e_max_fin;
    logic [51:0] nan_frac;
    logic [63:0] d_result;
    logic [4:0]  d_flags;

    always_comb begin
        carry     = s1_dbl ? s1_mant[53] : s1_mant[24];
        m_rnd     = carry ? (s1_mant >> 1) : s1_mant;
        e_rnd     = {1'b0, s1_expo} + {14'd0, carry};
        hidden    = s1_dbl ? m_rnd[52] : m_rnd[23];
        if (e_rnd == 15'd0 && hidden)
            e_rnd = 15'd1;
        emax      = s1_dbl ? 15'd2047 : 15'd255;
        ovf       = (e_rnd >= emax) || (s1_near_carry && (({1'b0, s1_expo} + 15'd1) >= emax));
        case (s1_rm)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = s1_sig;
            RM_RUP:  to_inf = !s1_sig;
            default: to_inf = 1'b1;
        endcase
        e_all     = 11'h7FF;
        e_max_fin = s1_dbl ? 11'h7FE : 11'h0FE;
        nan_frac  = s1_dbl ? 52'h8_0000_0000_0000 : 52'h0_0000_0040_0000;
        d_result  = 64'd0;
        d_flags   = 5'd0;

        if (s1_snan) begin
            d_result = pack(s1_dbl, 1'b0, e_all, nan_frac);
            d_flags  = 5'b10000;
        end else if (s1_qnan) begin
            d_result = pack(s1_dbl, 1'b0, e_all, nan_frac);
        end else if (s1_dbz) begin
            d_result = pack(s1_dbl, s1_sig, e_all, 52'd0);
            d_flags  = 5'b01000;
        end else if (s1_infs) begin
            d_result = pack(s1_dbl, s1_sig, e_all, 52'd0);
        end else if (s1_zero) begin
            d_result = pack(s1_dbl, s1_diff ? (s1_rm == RM_RDN) : s1_sig, 11'd0, 52'd0);
        end else if (ovf) begin
            d_result = to_inf ? pack(s1_dbl, s1_sig, e_all, 52'd0)
                              : pack(s1_dbl, s1_sig, e_max_fin, {52{1'b1}});
            d_flags  = 5'b00101;
`ifdef FP_RND_FTZ_EN
        end else if (s1_tiny && (m_rnd != 54'd0 || s1_inx)) begin
            d_result = pack(s1_dbl, s1_sig, 11'd0, 52'd0);
            d_flags  = 5'b00011;
`endif
        end else begin
            d_result = pack(s1_dbl, s1_sig, (m_rnd == 54'd0) ? 11'd0 : e_rnd[10:0], m_rnd[51:0]);
            d_flags  = {3'b000, s1_tiny & s1_inx, s1_inx};
        end
    end

    logic [63:0] out_result;
    logic [4:0]  out_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= 64'd0;
            out_flags  <= 5'd0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= d_result;
                out_flags  <= d_flags;
            end
        end
    end

    always_comb begin
        rnd_o        = '0;
        rnd_o.result = out_result;
        rnd_o.flags  = out_flags;
        rnd_o.ready  = s2_valid;
    end

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// tb/tb_fp_rnd_pipe.sv - randomized scoreboard bench for fp_rnd_pipe with literal anchors

module tb_fp_rnd_pipe;
    import fp_rnd_pipe_pkg::*;

    logic           clk;
    logic           rst;
    fp_rnd_in_type  rnd_i;
    logic           in_ready;
    fp_rnd_out_type rnd_o;
    logic           out_ready;

    fp_rnd_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .rnd_i     (rnd_i),
        .in_ready  (in_ready),
        .rnd_o     (rnd_o),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;

    fp_rnd_out_type q[$];
    fp_rnd_out_type exp_o;
    fp_rnd_out_type prev_out;
    bit             prev_hold = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [63:0] fpk(input bit dbl, input bit s, input int e, input longint unsigned frac);
        if (dbl)
            return (64'(s) << 63) | (64'(e) << 52) | frac;
        return 64'hFFFF_FFFF_0000_0000 | (64'(s) << 31) | (64'(e) << 23) | frac;
    endfunction

    function automatic fp_rnd_out_type model(input fp_rnd_in_type t);
        fp_rnd_out_type o;
        bit dbl, g, rr, st, nx, inc, ovf, to_inf;
        int p, emax, e, en;
        longint unsigned m, r, n, one;
        o       = '0;
        o.ready = 1'b1;
        dbl  = t.fmt[0];
        p    = dbl ? 52 : 23;
        emax = dbl ? 2047 : 255;
        one  = 64'd1 << p;
        if (t.snan || t.qnan) begin
            o.result = fpk(dbl, 0, emax, dbl ? (64'd1 << 51) : (64'd1 << 22));
            o.flags  = t.snan ? 5'b10000 : 5'b00000;
            return o;
        end
        if (t.dbz || t.infs) begin
            o.result = fpk(dbl, t.sig, emax, 0);
            o.flags  = t.dbz ? 5'b01000 : 5'b00000;
            return o;
        end
        if (t.zero) begin
            o.result = fpk(dbl, t.diff ? (t.rm == 3'd2) : t.sig, 0, 0);
            return o;
        end
        m  = t.mant;
        g  = t.grs[2];
        rr = t.grs[1];
        st = t.grs[0] || (t.rema != 0);
        nx = g || rr || st;
        case (t.rm)
            3'd1:    inc = 0;
            3'd2:    inc = t.sig && nx;
            3'd3:    inc = !t.sig && nx;
            3'd4:    inc = g;
            default: inc = g && (rr || st || m[0]);
        endcase
        r = m + 64'(inc);
        e = int'(t.expo);
        if (r >= 2 * one) begin
            r = r >> 1;
            e = e + 1;
        end
        if (e == 0 && r >= one) e = 1;
        n   = m + 64'(g);
        en  = int'(t.expo) + ((n >= 2 * one) ? 1 : 0);
        ovf = (e >= emax) || (en >= emax);
        if (ovf) begin
            to_inf   = (t.rm == 3'd1) ? 0 : (t.rm == 3'd2) ? t.sig : (t.rm == 3'd3) ? !t.sig : 1;
            o.result = to_inf ? fpk(dbl, t.sig, emax, 0) : fpk(dbl, t.sig, emax - 1, one - 1);
            o.flags  = 5'b00101;
            return o;
        end
`ifdef FP_RND_FTZ_EN
        if (t.expo == 0 && (r != 0 || nx)) begin
            o.result = fpk(dbl, t.sig, 0, 0);
            o.flags  = 5'b00011;
            return o;
        end
`endif
        o.result = fpk(dbl, t.sig, (r == 0) ? 0 : e, r & (one - 1));
        o.flags  = {3'b000, (t.expo == 0) && nx, nx};
        return o;
    endfunction

    function automatic fp_rnd_in_type mk(input bit dbl, input bit s, input int e,
                                          input longint unsigned mant, input logic [2:0] grs, input logic [2:0] rm);
        fp_rnd_in_type t;
        t      = '0;
        t.fmt  = {1'b0, dbl};
        t.sig  = s;
        t.expo = 14'(e);
        t.mant = 54'(mant);
        t.grs  = grs;
        t.rm   = rm;
        return t;
    endfunction

    function automatic fp_rnd_in_type rand_in();
        fp_rnd_in_type t;
        int p, emax, e;
        longint unsigned frac, one;
        t      = '0;
        t.fmt  = {1'b0, 1'($urandom_range(0, 1))};
        p      = t.fmt[0] ? 52 : 23;
        emax   = t.fmt[0] ? 2047 : 255;
        one    = 64'd1 << p;
        t.sig  = 1'($urandom_range(0, 1));
        t.rm   = 3'($urandom_range(0, 7));
        t.grs  = 3'($urandom);
        t.rema = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
        case ($urandom_range(0, 9))
            0:       e = 0;
            1:       e = emax - 1;
            2:       e = emax;
            3:       e = 1;
            4:       e = emax + int'($urandom_range(1, 50));
            default: e = int'($urandom_range(1, 32'(emax - 1)));
        endcase
        frac = {$urandom, $urandom} & (one - 1);
        if ($urandom_range(0, 3) == 0) frac = one - 1;
        t.expo = 14'(e);
        t.mant = 54'((e == 0) ? frac : (one | frac));
        case ($urandom_range(0, 15))
            0: t.snan = 1'b1;
            1: t.qnan = 1'b1;
            2: t.dbz  = 1'b1;
            3: t.infs = 1'b1;
            4: begin t.zero = 1'b1; t.diff = 1'($urandom_range(0, 1)); end
            5: {t.snan, t.qnan, t.dbz, t.infs, t.zero, t.diff} = 6'($urandom);
            default: ;
        endcase
        return t;
    endfunction

    // Scoreboard: in_ready predicted from occupancy, outputs popped in order.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            q.delete();
            prev_hold = 0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
            if (rnd_o.ready && q.size() == 0)
                chk("spurious_out", 64'(rnd_o.ready), 64'd0);
            if (prev_hold)
                chk("hold_stable", 64'(rnd_o.result ^ prev_out.result) | 64'(rnd_o.flags ^ prev_out.flags), 64'd0);
            if (rnd_o.ready && out_ready && q.size() != 0) begin
                exp_o = q.pop_front();
                n_out++;
                chk("sb_result", rnd_o.result, exp_o.result);
                chk("sb_flags", 64'(rnd_o.flags), 64'(exp_o.flags));
            end
            if (rnd_i.valid && in_ready)
                q.push_back(model(rnd_i));
            prev_hold = rnd_o.ready && !out_ready;
            prev_out  = rnd_o;
        end
    end

    task automatic run_dir(input string nm, input fp_rnd_in_type t,
                           input logic [63:0] er, input logic [4:0] ef);
        fp_rnd_out_type mo;
        int lat;
        mo = model(t);
        chk({nm, "_model_res"}, mo.result, er);
        chk({nm, "_model_flg"}, 64'(mo.flags), 64'(ef));
        @(negedge clk);
        rnd_i       = t;
        rnd_i.valid = 1'b1;
        out_ready   = 1'b1;
        @(negedge clk);
        rnd_i.valid = 1'b0;
        lat = 1;
        while (!rnd_o.ready && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd2);
        chk({nm, "_res"}, rnd_o.result, er);
        chk({nm, "_flg"}, 64'(rnd_o.flags), 64'(ef));
        @(negedge clk);
    endtask

    fp_rnd_in_type t;
    int  sent, outs0;
    bit  saw_low, acc;

    initial begin
        rst       = 1'b1;
        rnd_i     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_ready", 64'(rnd_o.ready), 64'd0);
        chk("rst_result", rnd_o.result, 64'd0);
        chk("rst_flags", 64'(rnd_o.flags), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_dir("d_one_tie", mk(1, 0, 1023, 64'd1 << 52, 3'b100, 3'd0), 64'h3FF0_0000_0000_0000, 5'b00001);
        run_dir("d_one_up", mk(1, 0, 1023, (64'd1 << 52) | 1, 3'b100, 3'd0), 64'h3FF0_0000_0000_0002, 5'b00001);
        run_dir("s_ovf_rne", mk(0, 0, 254, 64'hFF_FFFF, 3'b100, 3'd0), 64'hFFFF_FFFF_7F80_0000, 5'b00101);
        run_dir("s_ovf_rtz", mk(0, 0, 254, 64'hFF_FFFF, 3'b100, 3'd1), 64'hFFFF_FFFF_7F7F_FFFF, 5'b00101);
        t = mk(1, 0, 0, 0, 3'b000, 3'd0); t.snan = 1'b1;
        run_dir("d_snan", t, 64'h7FF8_0000_0000_0000, 5'b10000);
        t = mk(1, 0, 0, 0, 3'b000, 3'd2); t.zero = 1'b1; t.diff = 1'b1;
        run_dir("d_zero_rdn", t, 64'h8000_0000_0000_0000, 5'b00000);
`ifdef FP_RND_FTZ_EN
        run_dir("d_sub_up", mk(1, 0, 0, 64'h000F_FFFF_FFFF_FFFF, 3'b110, 3'd0), 64'h0, 5'b00011);
`else
        run_dir("d_sub_up", mk(1, 0, 0, 64'h000F_FFFF_FFFF_FFFF, 3'b110, 3'd0), 64'h0010_0000_0000_0000, 5'b00011);
`endif
        t = mk(0, 1, 0, 0, 3'b000, 3'd0); t.qnan = 1'b1;
        run_dir("s_qnan", t, 64'hFFFF_FFFF_7FC0_0000, 5'b00000);
        t = mk(1, 1, 0, 0, 3'b000, 3'd0); t.dbz = 1'b1;
        run_dir("d_dbz", t, 64'hFFF0_0000_0000_0000, 5'b01000);
        t = mk(0, 0, 0, 0, 3'b000, 3'd0); t.snan = 1'b1; t.dbz = 1'b1; t.zero = 1'b1;
        run_dir("s_prio", t, 64'hFFFF_FFFF_7FC0_0000, 5'b10000);
        run_dir("d_rup_neg", mk(1, 1, 2046, 64'h001F_FFFF_FFFF_FFFF, 3'b001, 3'd3), 64'hFFEF_FFFF_FFFF_FFFF, 5'b00001);
        run_dir("d_rdn_neg", mk(1, 1, 2046, 64'h001F_FFFF_FFFF_FFFF, 3'b001, 3'd2), 64'hFFF0_0000_0000_0000, 5'b00101);

        outs0   = n_out;
        sent    = 0;
        saw_low = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (sent < 4) begin
                rnd_i       = mk(1, 0, 1000 + sent, (64'd1 << 52) | 64'(sent), 3'b000, 3'd0);
                rnd_i.valid = 1'b1;
            end else begin
                rnd_i.valid = 1'b0;
            end
            out_ready = !(cyc >= 3 && cyc <= 5);
            #2;
            if (!in_ready) saw_low = 1;
            if (rnd_i.valid && in_ready) sent++;
        end
        chk("bp_in_ready_dropped", 64'(saw_low), 64'd1);
        chk("bp_sent", 64'(sent), 64'd4);
        chk("bp_outputs", 64'(n_out - outs0), 64'd4);

        @(negedge clk);
        rnd_i       = mk(1, 0, 1023, 64'd1 << 52, 3'b000, 3'd0);
        rnd_i.valid = 1'b1;
        out_ready   = 1'b0;
        @(negedge clk);
        rnd_i       = mk(0, 1, 100, 64'h80_0001, 3'b000, 3'd0);
        rnd_i.valid = 1'b1;
        @(negedge clk);
        rnd_i.valid = 1'b0;
        #1;
        chk("full_ready", 64'(rnd_o.ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 64'(rnd_o.ready), 64'd0);
        chk("mid_rst_result", rnd_o.result, 64'd0);
        chk("mid_rst_flags", 64'(rnd_o.flags), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        outs0     = n_out;
        repeat (6) @(negedge clk);
        #2;
        chk("mid_rst_no_stale", 64'(n_out - outs0), 64'd0);

        acc = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!rnd_i.valid || acc) begin
                rnd_i       = rand_in();
                rnd_i.valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            acc = rnd_i.valid && in_ready;
        end

        @(negedge clk);
        rnd_i.valid = 1'b0;
        out_ready   = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
